mcp4725_i2c_target: RTL and testbench

//  I2C target (slave) that receives MCP4725 fast-mode write frames: START, addr+W, ACK,

---
 rtl/mcp4725_i2c_target_pkg.sv | 13 +
 rtl/mcp4725_i2c_target_if.sv | 9 +
 rtl/mcp4725_i2c_target_i2c_line_sync.sv | 37 +++
 rtl/mcp4725_i2c_target.sv | 111 +++++++++++
 tb/tb_mcp4725_i2c_target.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mcp4725_i2c_target_pkg.sv
// mcp4725_i2c_target_pkg: state encoding, device address and byte1 field positions
// shared by the MCP4725 target and the DAC master.
package mcp4725_i2c_target_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_BYTE1, ST_ACK1, ST_BYTE2, ST_ACK2, ST_IGNORE
    } state_t;
    localparam logic [6:0] MCP4725_ADDR = 7'h60;
    localparam int C2 = 7, C1 = 6, PD1 = 5, PD0 = 4;
    localparam logic [1:0] FAST_MODE = 2'b00;
    function automatic logic is_fast(input logic [7:0] b1);
        return {b1[C2], b1[C1]} == FAST_MODE;
    endfunction
endpackage

// File: rtl/mcp4725_i2c_target_if.sv
// mcp4725_i2c_target_if: I2C pins plus the decoded DAC outputs of the target.
interface mcp4725_i2c_target_if;
    logic        scl_i, sda_i, sda_oe;
    logic [11:0] dac_code;
    logic [1:0]  pd;
    logic        code_valid, busy, cmd_err;
    modport slave (input scl_i, sda_i, output sda_oe, dac_code, pd, code_valid, busy, cmd_err);
    modport master(output scl_i, sda_i, input sda_oe, dac_code, pd, code_valid, busy, cmd_err);
endinterface

// File: rtl/mcp4725_i2c_target_i2c_line_sync.sv
// i2c_line_sync: synchronizes SCL/SDA and flags SCL edges plus START/STOP conditions.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [SYNC_STAGES-1:0] scl_sr, sda_sr;
    logic scl, scl_h, sda_h;
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sr <= '1;
            sda_sr <= '1;
            scl_h  <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_i};
            sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_i};
            scl_h  <= scl;
            sda_h  <= sda;
        end
    end
    assign scl      = scl_sr[SYNC_STAGES-1];
    assign sda      = sda_sr[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_h;
    assign scl_fall = ~scl & scl_h;
    // SDA edges only count as START/STOP while SCL is stably high
    assign start    = scl & scl_h & sda_h & ~sda;
    assign stop     = scl & scl_h & ~sda_h & sda;
endmodule

// File: rtl/mcp4725_i2c_target.sv
// mcp4725_i2c_target: I2C write-only target decoding MCP4725 fast-mode frames into
// a 12-bit DAC code and power-down bits.
module mcp4725_i2c_target
    import mcp4725_i2c_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = MCP4725_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input logic                    clk,
    input logic                    rst,
    mcp4725_i2c_target_if.slave    bus
);
    state_t state, state_n, shift_exit, ack_exit;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n, hold, hold_n, byte_in;
    logic [11:0] code, code_n;
    logic [1:0] pd, pd_n;
    logic oe, oe_n, valid, valid_n, err, err_n;
    logic sda, scl_rise, scl_fall, start, stop;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst(rst), .scl_i(bus.scl_i), .sda_i(bus.sda_i),
        .sda(sda), .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            hold    <= '0;
            code    <= '0;
            pd      <= '0;
            oe      <= 1'b0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            hold    <= hold_n;
            code    <= code_n;
            pd      <= pd_n;
            oe      <= oe_n;
            valid   <= valid_n;
            err     <= err_n;
        end
    end

    assign byte_in    = {shreg[6:0], sda};
    assign shift_exit = (state == ST_ADDR) ? ((byte_in == {DEV_ADDR, 1'b0}) ? ST_ADDR_ACK : ST_IGNORE)
                      : (state == ST_BYTE1) ? ST_ACK1 : ST_ACK2;
    assign ack_exit   = (state == ST_ACK1) ? ST_BYTE2 : ST_BYTE1;

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        hold_n    = hold;
        code_n    = code;
        pd_n      = pd;
        oe_n      = oe;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        if (start) begin
            state_n   = ST_ADDR;
            bit_cnt_n = '0;
            shreg_n   = '0;
            oe_n      = 1'b0;
        end else if (stop) begin
            state_n = ST_IDLE;
            oe_n    = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_BYTE1, ST_BYTE2: if (scl_rise) begin
                    shreg_n   = byte_in;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = shift_exit;
                        hold_n  = (state == ST_BYTE1) ? byte_in : hold;
                    end
                end
                ST_ADDR_ACK, ST_ACK1, ST_ACK2: begin
                    // first fall after bit 8 grabs SDA, the fall after the ACK clock releases it
                    if (scl_fall) begin
                        oe_n    = !oe;
                        state_n = oe ? ack_exit : state;
                    end
                    if (scl_rise && state == ST_ACK2) begin
                        if (is_fast(hold)) begin
                            code_n  = {hold[3:0], shreg};
                            pd_n    = {hold[PD1], hold[PD0]};
                            valid_n = 1'b1;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                ST_IGNORE: oe_n = 1'b0;
                default: state_n = state;
            endcase
        end
    end

    assign bus.sda_oe     = oe;
    assign bus.dac_code   = code;
    assign bus.pd         = pd;
    assign bus.code_valid = valid;
    assign bus.cmd_err    = err;
    assign bus.busy       = state != ST_IDLE;
endmodule

// File: tb/tb_mcp4725_i2c_target.sv
// tb_mcp4725_i2c_target: open-drain I2C master driving write frames into the target,
// checked against a frame-level model of MCP4725 fast-mode writes.
module tb_mcp4725_i2c_target;
    localparam int Q = 20;
    logic clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1;
    int checks = 0, errors = 0;

    mcp4725_i2c_target_if bus();
    assign bus.scl_i = m_scl;
    assign bus.sda_i = m_sda & ~bus.sda_oe;
    mcp4725_i2c_target dut(.clk(clk), .rst(rst), .bus(bus));
    always #10 clk = ~clk;

    logic [7:0]  frame[$];
    bit          got_acks[$], exp_acks[$];
    logic [13:0] got_upd[$], exp_upd[$];
    int          got_errs, exp_errs;
    bit          oe_seen, busy_mid;
    logic [11:0] exp_code = '0;
    logic [1:0]  exp_pd = '0;

    always @(negedge clk) begin
        if (bus.code_valid) got_upd.push_back({bus.pd, bus.dac_code});
        if (bus.cmd_err) got_errs++;
        if (bus.sda_oe) oe_seen = 1'b1;
    end

    // Model: a frame addressed to C0 is ACKed throughout; each complete byte pair
    // is one update when C2:C1 are zero, otherwise one command error.
    function automatic void model_frame();
        bit hit = frame[0] == 8'hC0;
        foreach (frame[i]) exp_acks.push_back(hit);
        if (hit)
            for (int i = 1; i + 1 < frame.size(); i += 2)
                if (frame[i][7:6] == 2'b00) begin
                    exp_code = {frame[i][3:0], frame[i+1]};
                    exp_pd   = frame[i][5:4];
                    exp_upd.push_back({exp_pd, exp_code});
                end else exp_errs++;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic clear_obs();
        got_acks.delete(); got_upd.delete(); exp_acks.delete(); exp_upd.delete();
        got_errs = 0; exp_errs = 0; oe_seen = 1'b0;
    endtask
    task automatic send_bit(input logic b);
        m_sda = b; tick(Q); m_scl = 1'b1; tick(2*Q); m_scl = 1'b0; tick(Q);
    endtask
    task automatic write_byte(input logic [7:0] b, output bit ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q);
        ack = !bus.sda_i;
        tick(Q); m_scl = 1'b0; tick(Q);
    endtask
    task automatic i2c_start();
        m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b0; tick(Q);
    endtask
    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
    endtask
    task automatic do_frame(input bit with_stop);
        bit a;
        i2c_start();
        foreach (frame[i]) begin
            write_byte(frame[i], a);
            got_acks.push_back(a);
        end
        busy_mid = bus.busy;
        if (with_stop) begin
            i2c_stop();
            tick(Q);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(5); rst = 1'b0; tick(5);
        checks++;
        if ({bus.sda_oe, bus.code_valid, bus.busy, bus.cmd_err} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.sda_oe, bus.code_valid, bus.busy, bus.cmd_err});
        end
        checks++;
        if ({bus.pd, bus.dac_code} !== 14'h0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0000", {bus.pd, bus.dac_code});
        end
    endtask

    task automatic test_single_write();
        clear_obs(); frame = {8'hC0, 8'h0A, 8'hB0}; model_frame(); do_frame(1);
        foreach (exp_acks[i]) begin
            checks++;
            if (got_acks[i] !== exp_acks[i]) begin
                errors++; $display("FAIL single_ack[%0d]: got %0b expected %0b", i, got_acks[i], exp_acks[i]);
            end
        end
        checks++;
        if (busy_mid !== 1'b1) begin errors++; $display("FAIL single_busy_mid: got %0b expected 1", busy_mid); end
        checks++;
        if (got_upd.size() != 1 || got_upd[0] !== {2'b00, 12'hAB0}) begin
            errors++; $display("FAIL single_update: got %0d pulses first %h expected 1 pulse 0AB0", got_upd.size(), got_upd[0]);
        end
        checks++;
        if ({bus.busy, bus.pd, bus.dac_code} !== {1'b0, 2'b00, 12'hAB0}) begin
            errors++; $display("FAIL single_final: got busy %0b pd %b code %h expected 0 00 AB0", bus.busy, bus.pd, bus.dac_code);
        end
    endtask

    task automatic test_wrong_addr();
        clear_obs(); frame = {8'hC2, 8'h0A, 8'hB0}; model_frame(); do_frame(1);
        foreach (exp_acks[i]) begin
            checks++;
            if (got_acks[i] !== exp_acks[i]) begin
                errors++; $display("FAIL wrong_addr_ack[%0d]: got %0b expected %0b", i, got_acks[i], exp_acks[i]);
            end
        end
        checks++;
        if (oe_seen || got_upd.size() != 0 || bus.dac_code !== 12'hAB0) begin
            errors++; $display("FAIL wrong_addr_quiet: got oe_seen %0b pulses %0d code %h expected 0 0 AB0", oe_seen, got_upd.size(), bus.dac_code);
        end
    endtask

    task automatic test_read_addr();
        clear_obs(); frame = {8'hC1}; model_frame(); do_frame(0);
        checks++;
        if (got_acks[0] !== 1'b0 || oe_seen) begin
            errors++; $display("FAIL read_no_ack: got ack %0b oe_seen %0b expected 0 0", got_acks[0], oe_seen);
        end
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL read_ignore_busy: got %0b expected 1", bus.busy); end
        i2c_stop(); tick(Q);
        checks++;
        if (bus.busy !== 1'b0 || got_upd.size() != 0 || bus.dac_code !== 12'hAB0) begin
            errors++; $display("FAIL read_after_stop: got busy %0b pulses %0d code %h expected 0 0 AB0", bus.busy, got_upd.size(), bus.dac_code);
        end
    endtask

    task automatic test_back_to_back();
        clear_obs(); frame = {8'hC0, 8'h0F, 8'hFF, 8'h01, 8'h23}; model_frame(); do_frame(1);
        checks++;
        if (got_upd.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d expected 2", got_upd.size());
        end else begin
            checks++;
            if (got_upd[0] !== {2'b00, 12'hFFF} || got_upd[1] !== {2'b00, 12'h123}) begin
                errors++; $display("FAIL b2b_values: got %h %h expected 0FFF 0123", got_upd[0], got_upd[1]);
            end
        end
    endtask

    task automatic test_cmd_err();
        clear_obs(); frame = {8'hC0, 8'h4A, 8'hBC}; model_frame(); do_frame(1);
        checks++;
        if (got_errs != 1 || got_upd.size() != 0 || bus.dac_code !== 12'h123) begin
            errors++; $display("FAIL cmd_err: got errs %0d pulses %0d code %h expected 1 0 123", got_errs, got_upd.size(), bus.dac_code);
        end
        clear_obs(); frame = {8'hC0, 8'h0A}; model_frame(); do_frame(1);
        checks++;
        if (got_acks.size() != 2 || !got_acks[0] || !got_acks[1]) begin
            errors++; $display("FAIL partial_acks: got %0d acks %0b%0b expected 2 acks 11", got_acks.size(), got_acks[0], got_acks[1]);
        end
        checks++;
        if (got_upd.size() != 0 || got_errs != 0 || bus.dac_code !== 12'h123) begin
            errors++; $display("FAIL partial_no_update: got pulses %0d errs %0d code %h expected 0 0 123", got_upd.size(), got_errs, bus.dac_code);
        end
    endtask

    task automatic test_reset_mid();
        bit a;
        clear_obs();
        i2c_start(); write_byte(8'hC0, a);
        for (int i = 7; i >= 0; i--) send_bit(i[0] ^ i[1] ? 1'b0 : 1'b0);
        checks++;
        if (bus.sda_oe !== 1'b1) begin errors++; $display("FAIL mid_ack_drive: got %0b expected 1", bus.sda_oe); end
        rst = 1'b1; tick(1);
        checks++;
        if ({bus.sda_oe, bus.busy, bus.pd, bus.dac_code} !== 16'h0) begin
            errors++; $display("FAIL mid_reset: got oe %0b busy %0b pd %b code %h expected all 0", bus.sda_oe, bus.busy, bus.pd, bus.dac_code);
        end
        rst = 1'b0; exp_code = '0; exp_pd = '0;
        i2c_stop(); tick(Q);
        clear_obs(); frame = {8'hC0, 8'h05, 8'h55}; model_frame(); do_frame(1);
        checks++;
        if (got_upd.size() != 1 || bus.dac_code !== 12'h555 || bus.pd !== 2'b00) begin
            errors++; $display("FAIL post_reset_frame: got pulses %0d code %h pd %b expected 1 555 00", got_upd.size(), bus.dac_code, bus.pd);
        end
    endtask

    task automatic test_repeated_start();
        clear_obs();
        frame = {8'hC0, 8'h0A}; model_frame(); do_frame(0);
        frame = {8'hC0, 8'h12, 8'h34}; model_frame(); do_frame(1);
        checks++;
        if (got_upd.size() != exp_upd.size() || got_upd[0] !== exp_upd[0]) begin
            errors++; $display("FAIL rep_start: got %0d pulses first %h expected %0d first %h", got_upd.size(), got_upd[0], exp_upd.size(), exp_upd[0]);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 5; f++) begin
            logic [7:0] b;
            int n = int'($urandom_range(1, 5));
            clear_obs();
            frame = {($urandom_range(3) == 0) ? 8'($urandom) : 8'hC0};
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                if (j % 2 == 0 && $urandom_range(3) != 0) b[7:6] = 2'b00;
                frame.push_back(b);
            end
            model_frame(); do_frame(1);
            foreach (exp_acks[i]) begin
                checks++;
                if (got_acks[i] !== exp_acks[i]) begin
                    errors++; $display("FAIL rand%0d_ack[%0d]: got %0b expected %0b", f, i, got_acks[i], exp_acks[i]);
                end
            end
            checks++;
            if (got_upd != exp_upd || got_errs != exp_errs) begin
                errors++; $display("FAIL rand%0d_updates: got %0d pulses %0d errs expected %0d pulses %0d errs", f, got_upd.size(), got_errs, exp_upd.size(), exp_errs);
            end
            checks++;
            if ({bus.pd, bus.dac_code} !== {exp_pd, exp_code}) begin
                errors++; $display("FAIL rand%0d_outputs: got %h expected %h", f, {bus.pd, bus.dac_code}, {exp_pd, exp_code});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_wrong_addr();
        test_read_addr();
        test_back_to_back();
        test_cmd_err();
        test_reset_mid();
        test_repeated_start();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
